// File: rtl/inst_rom_loader.sv
// Boot-loadable instruction memory: byte-stream loader fills the array,
// then serves combinational instruction fetches once boot_done_o is high.
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  input  logic                  load_start_i,
  input  logic                  load_valid_i,
  input  logic [7:0]            load_data_i,
  output logic                  load_ready_o,
  input  logic                  load_end_i,
  output logic [DEPTH_LOG2:0]   word_count_o,
  output logic                  overflow_o,
  output logic                  boot_done_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     asm_q, asm_d;
  logic [CW-1:0]   wc_q, wc_d;
  logic            ovf_q, ovf_d;
  logic            we;
  logic [31:0]     wdata;
  logic [31:0]     merged;
  logic            full;
  logic [31:0]     mem [DEPTH];

  assign full = (wc_q == CW'(DEPTH));

  // current byte dropped into its big-endian lane
  always_comb begin
    merged = asm_q;
    unique case (cnt_q)
      2'd0: merged[31:24] = load_data_i;
      2'd1: merged[23:16] = load_data_i;
      2'd2: merged[15:8]  = load_data_i;
      2'd3: merged[7:0]   = load_data_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    wc_d    = wc_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    wdata   = merged;
    unique case (state_q)
      IDLE, DONE: begin
        if (load_start_i) begin
          state_d = LOAD;
          cnt_d   = 2'd0;
          asm_d   = '0;
          wc_d    = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (load_valid_i) begin
          if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            asm_d = '0;
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              we   = 1'b1;
              wc_d = wc_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
            asm_d = merged;
          end
        end
        // end decision sees the post-accept byte count
        if (load_end_i) begin
          state_d = (cnt_d == 2'd0) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        wdata   = asm_q;
        state_d = DONE;
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we   = 1'b1;
          wc_d = wc_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      asm_q   <= '0;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      wc_q    <= wc_d;
      ovf_q   <= ovf_d;
    end
  end

  // array survives reset and restarts
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wc_q[DEPTH_LOG2-1:0]] <= wdata;
    end
  end

  logic                  hit;
  logic [DEPTH_LOG2-1:0] ridx;
  logic                  unused_lsb;

  assign unused_lsb = ^rom_addr_i[1:0];
  assign ridx       = rom_addr_i[DEPTH_LOG2+1:2];
  assign hit        = (state_q == DONE) && rom_ce_i
                    && (rom_addr_i[31:DEPTH_LOG2+2] == '0);
  assign rom_data_o = hit ? mem[ridx] : 32'h0;

  assign load_ready_o = (state_q == LOAD);
  assign boot_done_o  = (state_q == DONE);
  assign word_count_o = wc_q;
  assign overflow_o   = ovf_q;

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Boot-loadable instruction memory that answers the core's instruction-fetch port (`rom_ce`/`rom_addr` in, `rom_data` out). A byte-stream loader fills the word array after reset, and `boot_done_o` then releases the core. Fetches are served combinationally so the core's IF/ID register captures the instruction at the same edge that advances the PC. It sits beside the core at the top level, between the host/loader link and the fetch stage.

## Interface
- `DEPTH_LOG2`, default 10: log2 of word count; the array holds 2^DEPTH_LOG2 32-bit words.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rom_ce_i` in 1: fetch enable from the core.
- `rom_addr_i` in 32: fetch byte address from the core.
- `rom_data_o` out 32: fetched instruction; combinational.
- `load_start_i` in 1: begins or restarts a load session.
- `load_valid_i` in 1: a byte is offered on `load_data_i`.
- `load_data_i` in 8: load byte.
- `load_ready_o` out 1: high while bytes are accepted.
- `load_end_i` in 1: terminates the session.
- `word_count_o` out DEPTH_LOG2+1: words written this session.
- `overflow_o` out 1: sticky flag; bytes arrived past capacity.
- `boot_done_o` out 1: array valid; used to hold the core in reset until high.

## Operation
- States:
  - IDLE: entered on reset. Waits for `load_start_i`.
  - LOAD: `load_ready_o`=1.
  - FLUSH: lasts one cycle.
  - DONE: `boot_done_o`=1.
- Transitions:
  - IDLE: `load_start_i` goes to LOAD.
  - LOAD: `load_end_i` goes to DONE when no partial word is pending, otherwise to FLUSH.
  - FLUSH always goes to DONE.
  - DONE: `load_start_i` goes to LOAD.
  - `load_start_i` is ignored in LOAD and FLUSH.
- Entering LOAD clears the byte counter (2 bits), the word assembler, `word_count_o` and `overflow_o`.
- Byte acceptance: a byte is taken on a cycle with `load_valid_i` && `load_ready_o`.
- Big-endian packing: 1st byte goes to [31:24], 2nd to [23:16], 3rd to [15:8], 4th to [7:0].
- Word write: on accepting the 4th byte, the assembled word (including the current byte) is written to index `word_count_o`, `word_count_o` increments, and the byte counter wraps to 0.
- Capacity: if `word_count_o` == 2^DEPTH_LOG2 when a word completes, the write is dropped, the count holds and `overflow_o` is set.
- FLUSH: writes the partial word with unfilled low bytes zero, under the same capacity rule, then increments the count.
- Simultaneous `load_valid_i` and `load_end_i` in LOAD: the byte is accepted first; the end decision uses the post-accept byte count. A byte that completes a word therefore leads straight to DONE.
- Fetch: `rom_data_o` = mem[`rom_addr_i`[DEPTH_LOG2+1:2]] when state is DONE, `rom_ce_i`=1 and `rom_addr_i`[31:DEPTH_LOG2+2]==0.
  - Otherwise `rom_data_o` is 0, i.e. a nop.
  - `rom_addr_i`[1:0] is ignored.
- Array contents are not cleared by reset or by a restart.
- Locations beyond the last written word return stale data.

## Timing
- Reset values:
  - state IDLE.
  - `load_ready_o`=0, `boot_done_o`=0, `overflow_o`=0, `word_count_o`=0.
  - `rom_data_o`=0.
- Reset asserted mid-load aborts the session immediately: outputs take their reset values asynchronously, and already-written words remain.
- `load_ready_o` rises the cycle after `load_start_i` is sampled.
- A written word becomes visible on the fetch port only in DONE.
- `boot_done_o` rises:
  - one cycle after `load_end_i` with no partial word pending;
  - two cycles after it via FLUSH.
- On restart from DONE, `boot_done_o` falls the cycle after `load_start_i`.
- From the edge that `boot_done_o` falls, `rom_data_o` is 0.
- Fetch latency is 0 cycles: combinational from `rom_ce_i`/`rom_addr_i` in DONE.

## Test plan
- Basic load:
  - Stimulus: reset, `load_start_i`, bytes 34 01 00 05 00 00 00 00, then `load_end_i`.
  - Response: `word_count_o`=2 and `boot_done_o`=1.
  - Fetch addr 0x0 returns 0x34010005; fetch addr 0x4 returns 0x00000000; addr 0x5 also returns the word at index 1.
- Partial word:
  - Stimulus: bytes AA BB, then `load_end_i`.
  - Response: FLUSH occupies one cycle; `boot_done_o` rises two cycles after end; word 0 = 0xAABB0000; `word_count_o`=1.
- Simultaneous last byte and end:
  - Stimulus: 4th byte with `load_valid_i` and `load_end_i` high in the same cycle.
  - Response: word written, no FLUSH; `boot_done_o`=1 the next cycle.
- Overflow (`DEPTH_LOG2`=2):
  - Stimulus: 5 words streamed.
  - Response: `word_count_o`=4, `overflow_o`=1, word 0 intact.
  - A fetch of 0x10 (out of range) returns 0.
- Gating:
  - Stimulus: fetch with `rom_ce_i`=0, or in LOAD.
  - Response: 0.
  - Stimulus: `rst` low mid-load.
  - Response: all outputs 0 immediately; reload succeeds after release.
